// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multiport register file: clear-FSM states and
// one-hot enable decoding sized for the largest supported bank (32 registers).
package regfile_pkg;

    localparam int MAX_REGS = 32;
    localparam int IDX_W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DONE
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } idx_t;

    function automatic logic is_onehot(input logic [MAX_REGS-1:0] v);
        return (v != '0) && ((v & (v - 32'd1)) == '0);
    endfunction

    function automatic idx_t onehot_to_idx(input logic [MAX_REGS-1:0] v);
        idx_t r;
        r.valid = is_onehot(v);
        r.idx   = '0;
        for (int i = 0; i < MAX_REGS; i++) begin
            if (v[i]) r.idx = IDX_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux over the array with optional
// same-cycle forwarding of an accepted write.
module regfile_read_port #(
    parameter int  WIDTH  = 16,
    parameter int  NREGS  = 8,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic [WIDTH-1:0] regs [NREGS],
    input  logic [AW-1:0]    addr,
    input  logic             wr_hit,
    input  logic [AW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] data
);

    always_comb begin
        if ((BYPASS != 0) && wr_hit && (wr_idx == addr)) begin
            data = wr_data;
        end else begin
            data = regs[addr];
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// NREGS x WIDTH register bank: one one-hot write port, two read ports, illegal
// enable detection and a sequenced bulk-clear sweep (IDLE -> CLEAR -> DONE).
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int              WIDTH     = 16,
    parameter int              NREGS     = 8,
    parameter int              BYPASS    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int             AW        = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREGS-1:0] wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic             wr_err,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             clr_done
);

    state_t           state_q, state_d;
    logic [AW-1:0]    ptr_q;
    logic [WIDTH-1:0] mem [NREGS];

    idx_t             hit;
    logic             wr_ok;
    logic             multi_hot;
    logic [AW-1:0]    wr_idx;

    assign hit       = onehot_to_idx(MAX_REGS'(wr_en));
    assign wr_ok     = wr_ready && hit.valid;
    assign wr_idx    = hit.idx[AW-1:0];
    assign multi_hot = (wr_en & (wr_en - NREGS'(1))) != '0;

    // NOTE: sequential state uses <= so every flop samples pre-edge values;
    // blocking here would let one register see another's new value in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            wr_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Dropped writes during CLEAR are not flagged as illegal.
            wr_err  <= wr_ready && multi_hot;
            // NREGS is a power of two, so the increment wraps to 0 after the last index.
            if (state_q == CLEAR) ptr_q <= ptr_q + AW'(1);
        end
    end

    // NOTE: the array is reset explicitly because reset must load RESET_VAL into
    // every register immediately; a plain RAM macro without reset cannot be used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= RESET_VAL;
        end else if (state_q == CLEAR) begin
            mem[ptr_q] <= RESET_VAL;
        end else if (wr_ok) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (clr_req) state_d = CLEAR;
            CLEAR:   if (ptr_q == AW'(NREGS - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ready = (state_q != CLEAR);
        clr_busy = (state_q == CLEAR);
        clr_done = (state_q == DONE);
    end

    regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .BYPASS(BYPASS)) u_port_a (
        .regs    (mem),
        .addr    (rd_addr_a),
        .wr_hit  (wr_ok),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .data    (rd_data_a)
    );

    regfile_read_port #(.WIDTH(WIDTH), .NREGS(NREGS), .BYPASS(BYPASS)) u_port_b (
        .regs    (mem),
        .addr    (rd_addr_b),
        .wr_hit  (wr_ok),
        .wr_idx  (wr_idx),
        .wr_data (wr_data),
        .data    (rd_data_b)
    );

endmodule

// File: tb/tb_regfile_multiport.sv
// Bench for regfile_multiport: a behavioural model checks the 8x16 bypass instance
// every cycle; directed vectors cover BYPASS=0 and a 32x32 instance.
module tb_regfile_multiport;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  wr_en;
    logic [15:0] wr_data;
    logic [2:0]  rd_addr_a, rd_addr_b;
    logic        clr_req;

    logic        wr_ready, wr_err, clr_busy, clr_done;
    logic [15:0] rd_data_a, rd_data_b;

    logic        nb_ready, nb_err, nb_busy, nb_done;
    logic [15:0] nb_rd_a, nb_rd_b;

    logic [31:0] wr_en32, wr_data32;
    logic [4:0]  rd_addr_a32, rd_addr_b32;
    logic        clr_req32;
    logic        w_ready32, w_err32, c_busy32, c_done32;
    logic [31:0] rd_a32, rd_b32;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;
    int done_seen = 0;

    always #5 clk = ~clk;

    regfile_multiport #(.WIDTH(16), .NREGS(8), .BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_err(wr_err),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
    );

    regfile_multiport #(.WIDTH(16), .NREGS(8), .BYPASS(0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(nb_ready), .wr_err(nb_err),
        .rd_addr_a(rd_addr_a), .rd_data_a(nb_rd_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(nb_rd_b),
        .clr_req(clr_req), .clr_busy(nb_busy), .clr_done(nb_done)
    );

    regfile_multiport #(.WIDTH(32), .NREGS(32), .BYPASS(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en32), .wr_data(wr_data32),
        .wr_ready(w_ready32), .wr_err(w_err32),
        .rd_addr_a(rd_addr_a32), .rd_data_a(rd_a32),
        .rd_addr_b(rd_addr_b32), .rd_data_b(rd_b32),
        .clr_req(clr_req32), .clr_busy(c_busy32), .clr_done(c_done32)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: register contents, cycles of sweep remaining, pending pulses.
    logic [15:0] m [8];
    int          sweep_left;
    bit          done_f, err_f;
    bit          m_ready, n_done, n_err;

    task automatic model_reset();
        for (int k = 0; k < 8; k++) m[k] = 16'h0;
        sweep_left = 0;
        done_f     = 1'b0;
        err_f      = 1'b0;
    endtask

    always @(negedge rst_n) model_reset();

    always @(posedge clk) begin
        if (rst_n === 1'b1) begin
            m_ready = (sweep_left == 0);
            if (m_ready && $countones(wr_en) == 1) begin
                for (int k = 0; k < 8; k++) if (wr_en[k]) m[k] = wr_data;
            end
            n_err = m_ready && ($countones(wr_en) > 1);
            if (sweep_left > 0) begin
                m[8 - sweep_left] = 16'h0;
                sweep_left--;
                n_done = (sweep_left == 0);
            end else begin
                n_done = 1'b0;
                if (!done_f && clr_req) sweep_left = 8;
            end
            done_f = n_done;
            err_f  = n_err;
        end
    end

    function automatic logic [15:0] exp_rd(input logic [2:0] a);
        if (sweep_left == 0 && $countones(wr_en) == 1 && wr_en[a]) return wr_data;
        return m[a];
    endfunction

    always @(negedge clk) begin
        if (clr_done === 1'b1) done_seen++;
        if (cmp_on) begin
            check("cmp_wr_ready", 32'(wr_ready), 32'(sweep_left == 0));
            check("cmp_clr_busy", 32'(clr_busy), 32'(sweep_left > 0));
            check("cmp_clr_done", 32'(clr_done), 32'(done_f));
            check("cmp_wr_err",   32'(wr_err),   32'(err_f));
            check("cmp_rd_a",     32'(rd_data_a), 32'(exp_rd(rd_addr_a)));
            check("cmp_rd_b",     32'(rd_data_b), 32'(exp_rd(rd_addr_b)));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int busy_cnt, done_cnt, done_before;

    initial begin
        rst_n = 1'b0; wr_en = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0; clr_req = 1'b0;
        wr_en32 = '0; wr_data32 = '0; rd_addr_a32 = '0; rd_addr_b32 = '0; clr_req32 = 1'b0;
        model_reset();
        repeat (3) cyc();
        rst_n = 1'b1;
        cmp_on = 1'b1;
        #1;
        check("reset_ready", 32'(wr_ready), 32'd1);
        check("reset_busy",  32'(clr_busy), 32'd0);
        check("reset_done",  32'(clr_done), 32'd0);
        check("reset_err",   32'(wr_err),   32'd0);
        check("reset_rd_a",  32'(rd_data_a), 32'h0);

        // Single write then read back on both ports.
        cyc(); wr_en = 8'b0000_0100; wr_data = 16'hBEEF;
        cyc(); wr_en = 8'h00; rd_addr_a = 3'd2;
        #1; check("beef_rd_a", 32'(rd_data_a), 32'hBEEF);
        for (int i = 0; i < 8; i++) begin
            rd_addr_b = 3'(i);
            #1; check("beef_scan_b", 32'(rd_data_b), (i == 2) ? 32'hBEEF : 32'h0);
        end

        // Same-cycle bypass vs registered-only read.
        cyc(); wr_en = 8'b1000_0000; wr_data = 16'h1234; rd_addr_a = 3'd7; rd_addr_b = 3'd7;
        #1;
        check("byp_rd_a",    32'(rd_data_a), 32'h1234);
        check("byp_rd_b",    32'(rd_data_b), 32'h1234);
        check("nobyp_old_a", 32'(nb_rd_a),   32'h0);
        check("nobyp_old_b", 32'(nb_rd_b),   32'h0);
        cyc(); wr_en = 8'h00;
        #1;
        check("nobyp_new_a", 32'(nb_rd_a), 32'h1234);
        check("nobyp_new_b", 32'(nb_rd_b), 32'h1234);

        // Illegal multi-hot enable leaves registers alone and pulses wr_err once.
        cyc(); wr_en = 8'b0000_0001; wr_data = 16'h1111;
        cyc(); wr_en = 8'b0001_0000; wr_data = 16'h4444;
        cyc(); wr_en = 8'b0001_0001; wr_data = 16'hFFFF; rd_addr_a = 3'd0; rd_addr_b = 3'd4;
        #1;
        check("multi_nobyp_a", 32'(rd_data_a), 32'h1111);
        check("multi_nobyp_b", 32'(rd_data_b), 32'h4444);
        check("multi_err_lo",  32'(wr_err),    32'd0);
        cyc(); wr_en = 8'h00;
        #1;
        check("multi_err_hi", 32'(wr_err),    32'd1);
        check("multi_ready",  32'(wr_ready),  32'd1);
        check("multi_keep_a", 32'(rd_data_a), 32'h1111);
        check("multi_keep_b", 32'(rd_data_b), 32'h4444);
        cyc();
        check("multi_err_end", 32'(wr_err), 32'd0);

        // Bulk clear with a dropped mid-sweep write.
        for (int i = 0; i < 8; i++) begin
            cyc(); wr_en = 8'(1 << i); wr_data = 16'hA5A5;
        end
        cyc(); wr_en = 8'h00; clr_req = 1'b1;
        busy_cnt = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(); clr_req = 1'b0; wr_en = 8'h00;
            if (clr_done) done_cnt++;
            if (clr_busy) begin
                if (busy_cnt == 5) begin
                    wr_en = 8'b0000_1000; wr_data = 16'h1234;
                    check("sweep_ready_lo", 32'(wr_ready), 32'd0);
                end
                busy_cnt++;
            end
        end
        check("sweep_busy_cycles", 32'(busy_cnt), 32'd8);
        check("sweep_done_pulses", 32'(done_cnt), 32'd1);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            #1; check("sweep_cleared", 32'(rd_data_a), 32'h0);
        end

        // Async reset in the middle of a sweep.
        for (int i = 0; i < 8; i++) begin
            cyc(); wr_en = 8'(1 << i); wr_data = 16'hA5A5;
        end
        cyc(); wr_en = 8'h00; clr_req = 1'b1;
        cyc(); clr_req = 1'b0;
        repeat (3) cyc();
        check("abort_busy_before", 32'(clr_busy), 32'd1);
        rd_addr_b = 3'd5;
        #1; check("abort_pre_rd", 32'(rd_data_b), 32'hA5A5);
        done_before = done_seen;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(clr_busy), 32'd0);
        check("abort_done", 32'(clr_done), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            #0; check("abort_regs", 32'(rd_data_a), 32'h0);
        end
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (10) cyc();
        check("abort_no_done", 32'(done_seen), 32'(done_before));
        wr_en = 8'b0000_0010; wr_data = 16'h5555;
        cyc(); wr_en = 8'h00; rd_addr_a = 3'd1;
        #1; check("after_reset_wr", 32'(rd_data_a), 32'h5555);

        // 32x32 instance: fill every register through one-hot enables, read back on B.
        for (int i = 0; i < 32; i++) begin
            cyc(); wr_en32 = 32'd1 << i; wr_data32 = 32'hDEAD_0000 + 32'(i);
        end
        cyc(); wr_en32 = '0;
        for (int i = 0; i < 32; i++) begin
            rd_addr_b32 = 5'(i);
            #1; check("w32_rd_b", rd_b32, 32'hDEAD_0000 + 32'(i));
        end

        cyc();
        cmp_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
